keypad_event_scanner: RTL and testbench

Parametrised keypad front end. It scans a ROWS x COLS switch matrix, debounces every key, and holds a stable key bitmap. Each debounced press is also queued as an encoded key event in a small FIFO with a valid/ready interface. It replaces the fixed 4x4 pass-through latch between the matrix pins and the calculator logic.

---
 rtl/keypad_event_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_event_scanner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_scanner.sv
// Keypad matrix scanner: column drive, per-key debounce, stable key map,
// and a valid/ready FIFO of encoded press events.
//
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   column_pins     one-hot column drive
//   row_pins        row sense for the driven column
//   user_input      debounced key map, bit c*ROWS+r
//   key_valid       event FIFO non-empty
//   key_code        key index at FIFO head
//   key_ready       consumer accepts head
//   overflow        sticky press-event drop flag
module keypad_event_scanner #(
  parameter int COLS       = 4,
  parameter int ROWS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  output logic [COLS-1:0]               column_pins,
  input  logic [ROWS-1:0]               row_pins,
  output logic [ROWS*COLS-1:0]          user_input,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  input  logic                          key_ready,
  output logic                          overflow
);

  localparam int N  = ROWS * COLS;
  localparam int W  = $clog2(N);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    WALK
  } state_t;

  logic [DW-1:0]                div_cnt_q, div_cnt_d;
  logic [CW-1:0]                col_q, col_d;
  logic [N-1:0]                 raw_q, raw_d;
  logic [N-1:0][BW-1:0]         cnt_q, cnt_d;
  logic [N-1:0]                 user_q, user_d;
  logic [N-1:0]                 rise_q, rise_d;
  logic                         upd_q, upd_d;
  state_t                       state_q, state_d;
  logic [W-1:0]                 idx_q, idx_d;
  logic [FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]                wr_q, wr_d;
  logic [AW-1:0]                rd_q, rd_d;
  logic [AW:0]                  fill_q, fill_d;
  logic                         ovf_q, ovf_d;

  logic sample;
  logic frame_done;
  logic push;
  logic push_ok;
  logic pop;
  logic full;

  // Scan timing and raw capture of the driven column.
  always_comb begin
    sample     = (div_cnt_q == DW'(SCAN_DIV - 1));
    frame_done = sample && (col_q == CW'(COLS - 1));
    div_cnt_d  = sample ? '0 : div_cnt_q + DW'(1);
    col_d      = col_q;
    raw_d      = raw_q;
    if (sample) begin
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      for (int c = 0; c < COLS; c++) begin
        if (col_q == CW'(c)) begin
          raw_d[c*ROWS +: ROWS] = row_pins;
        end
      end
    end
  end

  // Debounce against the frame just completed, including the column
  // sampled on this very cycle.
  always_comb begin
    cnt_d  = cnt_q;
    user_d = user_q;
    rise_d = rise_q;
    upd_d  = frame_done;
    if (frame_done) begin
      for (int k = 0; k < N; k++) begin
        if (raw_d[k] != user_q[k]) begin
          if (cnt_q[k] == BW'(DEBOUNCE - 1)) begin
            user_d[k] = ~user_q[k];
            cnt_d[k]  = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + BW'(1);
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
      rise_d = user_d & ~user_q;
    end
  end

  // Walk the captured rise mask one index per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (upd_q && (|rise_q)) begin
          state_d = WALK;
          idx_d   = '0;
        end
      end
      WALK: begin
        push = rise_q[idx_q];
        if (idx_q == W'(N - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FIFO; a pop frees the slot a same-cycle push needs.
  always_comb begin
    full    = (fill_q == (AW+1)'(FIFO_DEPTH));
    pop     = (fill_q != '0) && key_ready;
    push_ok = push && (!full || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q || (push && !push_ok);
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (push_ok) begin
      mem_d[wr_q] = idx_q;
      wr_d        = wr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      fill_d = fill_q + (AW+1)'(1);
    end else if (!push_ok && pop) begin
      fill_d = fill_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      col_q     <= '0;
      raw_q     <= '0;
      cnt_q     <= '0;
      user_q    <= '0;
      rise_q    <= '0;
      upd_q     <= 1'b0;
      state_q   <= IDLE;
      idx_q     <= '0;
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      fill_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      col_q     <= col_d;
      raw_q     <= raw_d;
      cnt_q     <= cnt_d;
      user_q    <= user_d;
      rise_q    <= rise_d;
      upd_q     <= upd_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
    end
  end

  assign column_pins = COLS'(1) << col_q;
  assign user_input  = user_q;
  assign key_valid   = (fill_q != '0);
  assign key_code    = mem_q[rd_q];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Testbench for keypad_event_scanner: table vectors, corner sequences,
// and random stimulus against a queue-based reference model.
module tb_keypad_event_scanner;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int SDIV  = 8;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int N     = ROWS * COLS;
  localparam int W     = 4;
  localparam int FRAME = SDIV * COLS;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [COLS-1:0] column_pins;
  logic [ROWS-1:0] row_pins = '0;
  logic [N-1:0]    user_input;
  logic            key_valid;
  logic [W-1:0]    key_code;
  logic            key_ready = 1'b1;
  logic            overflow;

  keypad_event_scanner #(
    .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SDIV),
    .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .column_pins(column_pins), .row_pins(row_pins),
    .user_input(user_input), .key_valid(key_valid),
    .key_code(key_code), .key_ready(key_ready),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycle number since reset, debounced map,
  // scheduled pushes, and the event queue.
  int       mn;
  bit [N-1:0] m_raw, m_user;
  int       m_cnt[N];
  int       m_fifo[$];
  bit       m_ovf;
  int       sch_t[$];
  int       sch_k[$];

  bit [N-1:0] closed;
  int       got[$];
  int       got_t[$];

  typedef struct {
    int     key;
    bit [4:0] pat;
    int     exp_ev;
    bit     exp_bit;
  } vec_t;
  vec_t tbl[7];
  int okeys[5] = '{1, 2, 4, 8, 12};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (model cycle %0d)",
               name, act, req, mn);
    end
  endtask

  function automatic void model_reset();
    mn = 0;
    m_raw = '0;
    m_user = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_fifo.delete();
    m_ovf = 1'b0;
    sch_t.delete();
    sch_k.delete();
  endfunction

  function automatic void model_advance();
    int col;
    if (!RST_N) begin
      model_reset();
      return;
    end
    if (m_fifo.size() > 0 && key_ready) void'(m_fifo.pop_front());
    while (sch_t.size() > 0 && sch_t[0] == mn) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(sch_k[0]);
      else m_ovf = 1'b1;
      void'(sch_t.pop_front());
      void'(sch_k.pop_front());
    end
    col = (mn / SDIV) % COLS;
    if (mn % SDIV == SDIV - 1)
      for (int r = 0; r < ROWS; r++) m_raw[col*ROWS + r] = row_pins[r];
    if (mn % FRAME == FRAME - 1) begin
      for (int k = 0; k < N; k++) begin
        if (m_raw[k] != m_user[k]) begin
          m_cnt[k]++;
          if (m_cnt[k] == DEB) begin
            m_user[k] = ~m_user[k];
            m_cnt[k] = 0;
            if (m_user[k]) begin
              sch_t.push_back(mn + 2 + k);
              sch_k.push_back(k);
            end
          end
        end else begin
          m_cnt[k] = 0;
        end
      end
    end
    mn++;
  endfunction

  task automatic step();
    int col;
    logic [25:0] a_v, e_v;
    logic ev;
    logic [W-1:0] ec;
    col = (mn / SDIV) % COLS;
    row_pins = closed[col*ROWS +: ROWS];
    ev = (m_fifo.size() > 0);
    ec = '0;
    if (ev) ec = W'(m_fifo[0]);
    a_v = {column_pins, user_input, key_valid,
           key_valid ? key_code : 4'd0, overflow};
    e_v = {COLS'(1) << col, m_user, ev, ec, m_ovf};
    check("cycle", a_v, e_v);
    if (key_valid && key_ready) begin
      got.push_back(int'(key_code));
      got_t.push_back(mn);
    end
    model_advance();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    run(n);
    RST_N = 1'b1;
    got.delete();
    got_t.delete();
  endtask

  initial begin
    tbl[0] = '{6,  5'b11111, 1, 1'b1};
    tbl[1] = '{6,  5'b10111, 1, 1'b1};
    tbl[2] = '{6,  5'b11011, 0, 1'b0};
    tbl[3] = '{0,  5'b11100, 1, 1'b1};
    tbl[4] = '{15, 5'b11111, 1, 1'b1};
    tbl[5] = '{9,  5'b01110, 1, 1'b1};
    tbl[6] = '{12, 5'b00111, 1, 1'b1};

    closed = '0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();

    // Reset values and first column step.
    do_reset(3);
    check("rst_col", column_pins, 4'b0001);
    check("rst_user", user_input, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ovf", overflow, 0);
    run(7);
    check("col_hold", column_pins, 4'b0001);
    run(1);
    check("col_step", column_pins, 4'b0010);

    // Table: one key, per-frame closed/open pattern.
    for (int i = 0; i < 7; i++) begin
      closed = '0;
      do_reset(2);
      for (int f = 0; f < 5; f++) begin
        closed = tbl[i].pat[4-f] ? (N'(1) << tbl[i].key) : '0;
        run(FRAME);
      end
      closed = '0;
      run(24);
      check("tbl_events", got.size(), tbl[i].exp_ev);
      if (got.size() > 0) check("tbl_code", got[0], tbl[i].key);
      check("tbl_bit", user_input[tbl[i].key], tbl[i].exp_bit);
    end

    // Single key: rise timing, event timing, silent release.
    closed = '0;
    do_reset(2);
    closed = N'(1) << 6;
    run(95);
    check("single_pre", user_input[6], 0);
    run(1);
    check("single_rise", user_input[6], 1);
    run(40);
    check("single_n", got.size(), 1);
    if (got.size() > 0) begin
      check("single_code", got[0], 6);
      check("single_t", got_t[0], 104);
    end
    closed = '0;
    run(94);
    check("release_bit", user_input[6], 0);
    check("release_n", got.size(), 1);

    // Two keys in one frame: walk order and cycle.
    do_reset(2);
    closed = (N'(1) << 3) | (N'(1) << 9);
    run(120);
    check("simul_n", got.size(), 2);
    if (got.size() == 2) begin
      check("simul_c0", got[0], 3);
      check("simul_c1", got[1], 9);
      check("simul_t0", got_t[0], 101);
      check("simul_t1", got_t[1], 107);
    end

    // Overflow with consumer stalled, then drain.
    closed = '0;
    do_reset(2);
    key_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      closed = closed | (N'(1) << okeys[j]);
      run(FRAME);
    end
    run(90);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", key_valid, 1);
    check("ovf_head", key_code, 1);
    key_ready = 1'b1;
    got.delete();
    run(10);
    check("drain_n", got.size(), 4);
    if (got.size() == 4)
      for (int j = 0; j < 4; j++) check("drain_code", got[j], okeys[j]);
    check("drain_ovf", overflow, 1);
    check("drain_empty", key_valid, 0);

    // Reset in the middle of a walk with two events queued.
    closed = '0;
    do_reset(2);
    key_ready = 1'b0;
    closed = (N'(1) << 5) | (N'(1) << 10);
    run(108);
    check("mid_queued", key_valid, 1);
    closed = '0;
    RST_N = 1'b0;
    step();
    check("mid_valid", key_valid, 0);
    check("mid_user", user_input, 0);
    run(1);
    RST_N = 1'b1;
    key_ready = 1'b1;
    got.delete();
    run(200);
    check("mid_stale", got.size(), 0);

    // Random keys and back-pressure against the model.
    closed = '0;
    do_reset(2);
    for (int i = 0; i < 40 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0)
        closed[$urandom_range(0, N - 1)] ^= 1'b1;
      key_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
